// File: rtl/lifo_pop_streamer.sv
`default_nettype none
// ============================================================================
// Module   : lifo_pop_streamer
// Purpose  : Pops "N words" from a lifo on command and presents them as a
//            valid/ready packet stream with sop/eop. The lifo's 1-cycle read
//            latency is absorbed by a 4-entry output buffer with credit-based
//            read issue. Reports the number of words actually delivered.
// Revision : 1.0 - initial release
// ============================================================================
module lifo_pop_streamer #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 8
) (
    input  logic                clk_i,
    input  logic                srst_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [AWIDTH:0]     cmd_len_i,
    output logic                lifo_rdreq_o,
    input  logic [DWIDTH-1:0]   lifo_q_i,
    input  logic                lifo_empty_i,
    input  logic [AWIDTH:0]     lifo_usedw_i,
    output logic [DWIDTH-1:0]   src_data_o,
    output logic                src_valid_o,
    input  logic                src_ready_i,
    output logic                src_startofpacket_o,
    output logic                src_endofpacket_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [AWIDTH:0]     done_cnt_o
);

    localparam int             CW     = AWIDTH + 1;
    localparam logic [CW-1:0]  c_zero = '0;
    localparam logic [CW-1:0]  c_one  = CW'(1);
    localparam logic [2:0]     c_buf_depth = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_POP   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_remaining;
    logic [CW-1:0]      r_issued;
    logic [CW-1:0]      r_delivered;
    logic [CW-1:0]      r_done_cnt;

    // One read can be outstanding at the lifo; its sop/eop tags travel with it
    logic               r_inflight;
    logic               r_inflight_sop;
    logic               r_inflight_eop;

    // Output buffer storage and pointers
    logic [DWIDTH-1:0]  r_buf_data [4];
    logic [3:0]         r_buf_sop;
    logic [3:0]         r_buf_eop;
    logic [1:0]         r_wr_ptr;
    logic [1:0]         r_rd_ptr;
    logic [2:0]         r_count;

    logic [2:0]         w_occupancy;
    logic               w_rdreq;
    logic               w_is_sop;
    logic               w_is_eop;
    logic               w_valid;
    logic               w_xfer;
    logic               w_push;

    // Occupancy counts words already buffered plus the word still coming back
    // from the lifo, so a read is only issued when a slot is guaranteed free.
    assign w_occupancy = r_count + {2'b00, r_inflight};
    assign w_rdreq     = (r_state == ST_POP) && !lifo_empty_i &&
                         (r_remaining != c_zero) && (w_occupancy < c_buf_depth);
    assign w_is_sop    = (r_issued == c_zero);
    // Last word either by request length or because the lifo is about to run dry
    assign w_is_eop    = (r_remaining == c_one) || (lifo_usedw_i == c_one);
    assign w_valid     = (r_count != 3'd0);
    assign w_xfer      = w_valid && src_ready_i;
    assign w_push      = r_inflight;

    // Output buffer: capture lifo data the cycle after a read, pop on transfer
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_inflight     <= 1'b0;
            r_inflight_sop <= 1'b0;
            r_inflight_eop <= 1'b0;
            r_wr_ptr       <= 2'd0;
            r_rd_ptr       <= 2'd0;
            r_count        <= 3'd0;
            r_buf_sop      <= 4'd0;
            r_buf_eop      <= 4'd0;
        end else begin
            r_inflight     <= w_rdreq;
            r_inflight_sop <= w_is_sop;
            r_inflight_eop <= w_is_eop;
            if (w_push) begin
                r_buf_data[r_wr_ptr] <= lifo_q_i;
                r_buf_sop[r_wr_ptr]  <= r_inflight_sop;
                r_buf_eop[r_wr_ptr]  <= r_inflight_eop;
                r_wr_ptr             <= r_wr_ptr + 2'd1;
            end
            if (w_xfer) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_push, w_xfer})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Command sequencing: IDLE -> POP -> DRAIN -> DONE, with length/issue/delivery accounting
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_state     <= ST_IDLE;
            r_remaining <= c_zero;
            r_issued    <= c_zero;
            r_delivered <= c_zero;
            r_done_cnt  <= c_zero;
        end else begin
            if (w_xfer) begin
                r_delivered <= r_delivered + c_one;
            end
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        r_remaining <= cmd_len_i;
                        r_issued    <= c_zero;
                        r_delivered <= c_zero;
                        if (cmd_len_i == c_zero) begin
                            r_done_cnt <= c_zero;
                            r_state    <= ST_DONE;
                        end else begin
                            r_state    <= ST_POP;
                        end
                    end
                end
                ST_POP: begin
                    if (lifo_empty_i && (r_issued == c_zero)) begin
                        // Nothing to pop at all: finish without emitting a packet
                        r_done_cnt <= r_delivered;
                        r_state    <= ST_DONE;
                    end else if (w_rdreq) begin
                        r_remaining <= r_remaining - c_one;
                        r_issued    <= r_issued + c_one;
                        if (w_is_eop) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if ((r_count == 3'd0) && !r_inflight) begin
                        r_done_cnt <= r_delivered;
                        r_state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o         = (r_state == ST_IDLE);
    assign busy_o              = (r_state != ST_IDLE);
    assign done_o              = (r_state == ST_DONE);
    assign done_cnt_o          = r_done_cnt;
    assign lifo_rdreq_o        = w_rdreq;
    assign src_valid_o         = w_valid;
    // Head fields are masked while the buffer is empty so idle outputs read as 0
    assign src_data_o          = w_valid ? r_buf_data[r_rd_ptr] : '0;
    assign src_startofpacket_o = w_valid && r_buf_sop[r_rd_ptr];
    assign src_endofpacket_o   = w_valid && r_buf_eop[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_lifo_pop_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lifo_pop_streamer
// Purpose  : Directed self-checking bench for lifo_pop_streamer with a
//            behavioural lifo (1-cycle read latency) in front of it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lifo_pop_streamer;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int CW = AW + 1;

    logic          clk = 1'b0;
    logic          srst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [CW-1:0] cmd_len = '0;
    logic          lifo_rdreq;
    logic [DW-1:0] lifo_q;
    logic          lifo_empty;
    logic [CW-1:0] lifo_usedw;
    logic [DW-1:0] src_data;
    logic          src_valid;
    logic          src_ready = 1'b0;
    logic          src_sop;
    logic          src_eop;
    logic          busy;
    logic          done;
    logic [CW-1:0] done_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lifo_pop_streamer #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk_i               (clk),
        .srst_i              (srst),
        .cmd_valid_i         (cmd_valid),
        .cmd_ready_o         (cmd_ready),
        .cmd_len_i           (cmd_len),
        .lifo_rdreq_o        (lifo_rdreq),
        .lifo_q_i            (lifo_q),
        .lifo_empty_i        (lifo_empty),
        .lifo_usedw_i        (lifo_usedw),
        .src_data_o          (src_data),
        .src_valid_o         (src_valid),
        .src_ready_i         (src_ready),
        .src_startofpacket_o (src_sop),
        .src_endofpacket_o   (src_eop),
        .busy_o              (busy),
        .done_o              (done),
        .done_cnt_o          (done_cnt)
    );

    // Behavioural lifo: read data appears on q one cycle after rdreq
    logic [DW-1:0] lmem [256];
    logic [CW-1:0] lused = '0;
    logic          lwr = 1'b0;
    logic          lclr = 1'b1;
    logic [DW-1:0] lwd = '0;

    always @(posedge clk) begin
        if (lclr) begin
            lused <= '0;
        end else if (lifo_rdreq && (lused != '0)) begin
            lifo_q <= lmem[lused[7:0] - 8'd1];
            lused  <= lused - 9'd1;
        end else if (lwr) begin
            lmem[lused[7:0]] <= lwd;
            lused            <= lused + 9'd1;
        end
    end
    assign lifo_empty = (lused == '0);
    assign lifo_usedw = lused;

    // Stream / handshake monitor
    logic          mon_clr = 1'b1;
    int            cyc = 0;
    int            beats = 0;
    int            valid_cnt = 0;
    int            rd_cnt = 0;
    int            rd_empty = 0;
    int            outst = 0;
    int            max_outst = 0;
    int            stall_bad = 0;
    int            done_seen = 0;
    int            sop_cnt = 0;
    int            eop_cnt = 0;
    int            hs_cyc = -1;
    int            first_rd_cyc = -1;
    int            first_val_cyc = -1;
    int            done_cyc = -1;
    logic [CW-1:0] done_val = '0;
    logic [DW-1:0] bd [$];
    logic          bs [$];
    logic          be [$];
    logic          p_stall = 1'b0;
    logic [DW-1:0] p_data = '0;
    logic          p_sop = 1'b0;
    logic          p_eop = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (mon_clr) begin
            beats <= 0; valid_cnt <= 0; rd_cnt <= 0; rd_empty <= 0;
            outst <= 0; max_outst <= 0; stall_bad <= 0; done_seen <= 0;
            sop_cnt <= 0; eop_cnt <= 0;
            hs_cyc <= -1; first_rd_cyc <= -1; first_val_cyc <= -1; done_cyc <= -1;
            p_stall <= 1'b0;
            bd.delete(); bs.delete(); be.delete();
        end else begin
            if (cmd_valid && cmd_ready) hs_cyc <= cyc;
            if (lifo_rdreq) begin
                rd_cnt <= rd_cnt + 1;
                if (first_rd_cyc < 0) first_rd_cyc <= cyc;
            end
            if (lifo_rdreq && lifo_empty) rd_empty <= rd_empty + 1;
            if (src_valid) begin
                valid_cnt <= valid_cnt + 1;
                if (first_val_cyc < 0) first_val_cyc <= cyc;
            end
            outst <= outst + int'(lifo_rdreq) - int'(src_valid && src_ready);
            if (outst > max_outst) max_outst <= outst;
            if (p_stall && (!src_valid || src_data !== p_data ||
                            src_sop !== p_sop || src_eop !== p_eop))
                stall_bad <= stall_bad + 1;
            p_stall <= src_valid && !src_ready;
            p_data  <= src_data;
            p_sop   <= src_sop;
            p_eop   <= src_eop;
            if (src_valid && src_ready) begin
                beats <= beats + 1;
                bd.push_back(src_data);
                bs.push_back(src_sop);
                be.push_back(src_eop);
                if (src_sop) sop_cnt <= sop_cnt + 1;
                if (src_eop) eop_cnt <= eop_cnt + 1;
            end
            if (done) begin
                done_seen <= done_seen + 1;
                done_val  <= done_cnt;
                if (done_cyc < 0) done_cyc <= cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    task automatic lifo_clear();
        lclr = 1'b1;
        tick();
        lclr = 1'b0;
    endtask

    task automatic lifo_push(input logic [DW-1:0] d);
        lwr = 1'b1;
        lwd = d;
        tick();
        lwr = 1'b0;
    endtask

    task automatic send_cmd(input logic [CW-1:0] len);
        cmd_valid = 1'b1;
        cmd_len   = len;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int i;
        i = 0;
        while (done_seen == 0 && i < budget) begin
            tick();
            i++;
        end
        checks++;
        if (done_seen == 0) begin
            errors++;
            $display("FAIL %s_done_timeout: done pulses=%0d required=1", name, done_seen);
        end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        srst = 1'b1;
        lclr = 1'b1;
        repeat (3) tick();
        checks++;
        if ({cmd_ready, busy, src_valid, done, lifo_rdreq, src_sop, src_eop} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_ctrl: {rdy,busy,val,done,rd,sop,eop}=%b required=1000000",
                     {cmd_ready, busy, src_valid, done, lifo_rdreq, src_sop, src_eop});
        end
        checks++;
        if (done_cnt !== 9'd0 || src_data !== 16'd0) begin
            errors++;
            $display("FAIL reset_data: done_cnt=%0d data=%h required 0 and 0000", done_cnt, src_data);
        end
        srst = 1'b0;
        lclr = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        lifo_clear();
        lifo_push(16'h0A0A); lifo_push(16'h0B0B); lifo_push(16'h0C0C);
        lifo_push(16'h0D0D); lifo_push(16'h0E0E);
        src_ready = 1'b1;
        clear_mon();
        send_cmd(9'd3);
        wait_done(60, "basic");
        checks++;
        if (first_rd_cyc !== hs_cyc + 1) begin
            errors++;
            $display("FAIL basic_rd_latency: first rdreq cycle=%0d required=%0d", first_rd_cyc, hs_cyc + 1);
        end
        checks++;
        if (first_val_cyc !== first_rd_cyc + 2) begin
            errors++;
            $display("FAIL basic_valid_latency: first valid cycle=%0d required=%0d", first_val_cyc, first_rd_cyc + 2);
        end
        checks++;
        if (beats != 3) begin
            errors++;
            $display("FAIL basic_beats: got=%0d required=3", beats);
        end else begin
            checks++;
            if (bd[0] !== 16'h0E0E || bd[1] !== 16'h0D0D || bd[2] !== 16'h0C0C) begin
                errors++;
                $display("FAIL basic_data: got=%h,%h,%h required=0e0e,0d0d,0c0c", bd[0], bd[1], bd[2]);
            end
            checks++;
            if ({bs[0], bs[1], bs[2], be[0], be[1], be[2]} !== 6'b100_001) begin
                errors++;
                $display("FAIL basic_markers: sop/eop=%b required=100001",
                         {bs[0], bs[1], bs[2], be[0], be[1], be[2]});
            end
        end
        checks++;
        if (done_val !== 9'd3) begin
            errors++;
            $display("FAIL basic_done_cnt: got=%0d required=3", done_val);
        end
        checks++;
        if (lused !== 9'd2) begin
            errors++;
            $display("FAIL basic_usedw: got=%0d required=2", lused);
        end
        checks++;
        if (done_cnt !== 9'd3) begin
            errors++;
            $display("FAIL basic_done_cnt_hold: got=%0d required=3", done_cnt);
        end
    endtask

    task automatic test_truncate();
        lifo_clear();
        lifo_push(16'h1001); lifo_push(16'h1002); lifo_push(16'h1003);
        src_ready = 1'b1;
        clear_mon();
        send_cmd(9'd8);
        wait_done(60, "trunc");
        checks++;
        if (beats != 3) begin
            errors++;
            $display("FAIL trunc_beats: got=%0d required=3", beats);
        end else begin
            checks++;
            if (bd[0] !== 16'h1003 || bd[1] !== 16'h1002 || bd[2] !== 16'h1001) begin
                errors++;
                $display("FAIL trunc_data: got=%h,%h,%h required=1003,1002,1001", bd[0], bd[1], bd[2]);
            end
            checks++;
            if ({bs[0], bs[1], bs[2], be[0], be[1], be[2]} !== 6'b100_001) begin
                errors++;
                $display("FAIL trunc_markers: sop/eop=%b required=100001",
                         {bs[0], bs[1], bs[2], be[0], be[1], be[2]});
            end
        end
        checks++;
        if (done_val !== 9'd3) begin
            errors++;
            $display("FAIL trunc_done_cnt: got=%0d required=3", done_val);
        end
        checks++;
        if (rd_empty != 0 || rd_cnt != 3) begin
            errors++;
            $display("FAIL trunc_rdreq: reads=%0d reads_while_empty=%0d required 3 and 0", rd_cnt, rd_empty);
        end
    endtask

    task automatic test_empty();
        lifo_clear();
        src_ready = 1'b1;
        clear_mon();
        send_cmd(9'd4);
        wait_done(30, "empty");
        checks++;
        if (rd_cnt != 0 || valid_cnt != 0) begin
            errors++;
            $display("FAIL empty_activity: rdreq cycles=%0d valid cycles=%0d required 0 and 0", rd_cnt, valid_cnt);
        end
        checks++;
        if (done_cyc !== hs_cyc + 2) begin
            errors++;
            $display("FAIL empty_done_latency: done cycle=%0d required=%0d", done_cyc, hs_cyc + 2);
        end
        checks++;
        if (done_val !== 9'd0) begin
            errors++;
            $display("FAIL empty_done_cnt: got=%0d required=0", done_val);
        end
    endtask

    task automatic test_zero_len();
        lifo_clear();
        lifo_push(16'h7777); lifo_push(16'h8888);
        src_ready = 1'b1;
        clear_mon();
        send_cmd(9'd0);
        wait_done(30, "zero");
        checks++;
        if (done_cyc !== hs_cyc + 1) begin
            errors++;
            $display("FAIL zero_done_latency: done cycle=%0d required=%0d", done_cyc, hs_cyc + 1);
        end
        checks++;
        if (done_val !== 9'd0 || rd_cnt != 0 || valid_cnt != 0) begin
            errors++;
            $display("FAIL zero_result: done_cnt=%0d reads=%0d valids=%0d required 0,0,0", done_val, rd_cnt, valid_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] wv [256];
        int bad;
        int i;
        lifo_clear();
        for (int k = 0; k < 256; k++) begin
            wv[k] = DW'($urandom);
            lifo_push(wv[k]);
        end
        src_ready = 1'b0;
        clear_mon();
        send_cmd(9'd256);
        i = 0;
        while (done_seen == 0 && i < 3000) begin
            src_ready = 1'($urandom_range(0, 1));
            tick();
            i++;
        end
        src_ready = 1'b1;
        checks++;
        if (done_seen == 0) begin
            errors++;
            $display("FAIL bp_done_timeout: done pulses=%0d required=1", done_seen);
        end
        repeat (3) tick();
        checks++;
        if (beats != 256) begin
            errors++;
            $display("FAIL bp_beats: got=%0d required=256", beats);
        end
        bad = 0;
        for (int k = 0; k < beats && k < 256; k++) begin
            if (bd[k] !== wv[255 - k]) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_order: mismatched words=%0d required=0", bad);
        end
        checks++;
        if (sop_cnt != 1 || eop_cnt != 1 || beats != 256 || bs[0] !== 1'b1 || be[255] !== 1'b1) begin
            errors++;
            $display("FAIL bp_markers: sop_count=%0d eop_count=%0d required one sop on first, one eop on last",
                     sop_cnt, eop_cnt);
        end
        checks++;
        if (max_outst > 4) begin
            errors++;
            $display("FAIL bp_credit: max buffered+inflight=%0d required<=4", max_outst);
        end
        checks++;
        if (stall_bad != 0) begin
            errors++;
            $display("FAIL bp_stall_stable: unstable stall cycles=%0d required=0", stall_bad);
        end
        checks++;
        if (done_val !== 9'd256 || rd_empty != 0) begin
            errors++;
            $display("FAIL bp_done_cnt: got=%0d reads_while_empty=%0d required 256 and 0", done_val, rd_empty);
        end
    endtask

    task automatic test_single();
        lifo_clear();
        lifo_push(16'h5A5A);
        src_ready = 1'b1;
        clear_mon();
        send_cmd(9'd1);
        wait_done(30, "single");
        checks++;
        if (beats != 1) begin
            errors++;
            $display("FAIL single_beats: got=%0d required=1", beats);
        end else begin
            checks++;
            if (bd[0] !== 16'h5A5A || bs[0] !== 1'b1 || be[0] !== 1'b1) begin
                errors++;
                $display("FAIL single_beat: data=%h sop=%b eop=%b required 5a5a,1,1", bd[0], bs[0], be[0]);
            end
        end
        checks++;
        if (done_val !== 9'd1) begin
            errors++;
            $display("FAIL single_done_cnt: got=%0d required=1", done_val);
        end
    endtask

    task automatic test_reset_mid();
        int i;
        lifo_clear();
        for (int k = 0; k < 50; k++) lifo_push(16'h2000 + 16'(k));
        src_ready = 1'b1;
        clear_mon();
        send_cmd(9'd50);
        i = 0;
        while (beats < 10 && i < 200) begin
            tick();
            i++;
        end
        checks++;
        if (beats < 10) begin
            errors++;
            $display("FAIL rstmid_progress: beats=%0d required>=10", beats);
        end
        srst = 1'b1;
        tick();
        checks++;
        if ({src_valid, busy, cmd_ready, done} !== 4'b0010) begin
            errors++;
            $display("FAIL rstmid_state: {val,busy,rdy,done}=%b required=0010", {src_valid, busy, cmd_ready, done});
        end
        srst = 1'b0;
        repeat (3) tick();
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL rstmid_no_done: done pulses=%0d required=0", done_seen);
        end
        lifo_clear();
        lifo_push(16'h3001); lifo_push(16'h3002); lifo_push(16'h3003);
        clear_mon();
        send_cmd(9'd2);
        wait_done(40, "rstmid");
        checks++;
        if (beats != 2) begin
            errors++;
            $display("FAIL rstmid_beats: got=%0d required=2", beats);
        end else begin
            checks++;
            if (bd[0] !== 16'h3003 || bd[1] !== 16'h3002) begin
                errors++;
                $display("FAIL rstmid_data: got=%h,%h required=3003,3002", bd[0], bd[1]);
            end
        end
        checks++;
        if (done_val !== 9'd2) begin
            errors++;
            $display("FAIL rstmid_done_cnt: got=%0d required=2", done_val);
        end
    endtask

    initial begin
        test_reset();
        mon_clr = 1'b0;
        test_basic();
        test_truncate();
        test_empty();
        test_zero_len();
        test_backpressure();
        test_single();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
